// File: rtl/t05_sram_pkg.sv
// Shared definitions for the SRAM arbiter: requester count, widths,
// FSM state encoding and the per-requester SRAM region bases.
package t05_sram_pkg;

  localparam int unsigned NREQ = 3;   // histogram, tree/codebook, translation
  localparam int unsigned IW   = 2;   // requester index / pointer width
  localparam int unsigned AW   = 8;   // per-requester word index width
  localparam int unsigned DW   = 32;  // data width
  localparam int unsigned SAW  = 32;  // SRAM byte address width
  localparam int unsigned CW   = 8;   // WAIT counter width

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // 256-word region per requester
  localparam logic [SAW-1:0] BASE0 = 32'h3300_0000;
  localparam logic [SAW-1:0] BASE1 = 32'h3300_0400;
  localparam logic [SAW-1:0] BASE2 = 32'h3300_0800;

  // Region base for requester index
  function automatic logic [SAW-1:0] region_base(input logic [IW-1:0] idx);
    case (idx)
      2'd0:    region_base = BASE0;
      2'd1:    region_base = BASE1;
      default: region_base = BASE2;
    endcase
  endfunction

  // One-hot grant to index (grant assumed one-hot or zero)
  function automatic logic [IW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    onehot_idx = 2'd0;
    if (oh[1]) onehot_idx = 2'd1;
    if (oh[2]) onehot_idx = 2'd2;
  endfunction

endpackage

// File: rtl/t05_rr_select.sv
// Round-robin priority select: first asserted req bit scanning upward from
// ptr, wrapping from the top requester back to 0. Purely combinational.
// Ports: req  - request vector
//        ptr  - index with highest priority
//        grant- one-hot selected requester (0 if none)
//        valid- any request present
module t05_rr_select
  import t05_sram_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Scan NREQ positions starting at ptr, keep the first hit
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = IW'((int'(ptr) + i) % int'(NREQ));
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter giving three requesters single-word access to a
// shared SRAM manager. One transaction at a time:
// IDLE -> ISSUE (one-cycle strobe) -> WAIT (busy handshake / timeout)
// -> RESP (one-cycle ack or err) -> IDLE.
// Ports: clk, nrst          - clock, async active-low reset
//        req_i/wr_i/addr_i/wdata_i - per-requester request bundle
//        grant_o/ack_o/err_o - owner and completion pulses
//        rdata_o             - last read data
//        sram_*              - manager-side interface
module t05_sram_arbiter
  import t05_sram_pkg::*;
#(
  parameter logic [CW-1:0] TIMEOUT = 8'd255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ-1:0]     wr_i,
  input  logic [NREQ*AW-1:0]  addr_i,
  input  logic [NREQ*DW-1:0]  wdata_i,
  output logic [NREQ-1:0]     grant_o,
  output logic [NREQ-1:0]     ack_o,
  output logic [NREQ-1:0]     err_o,
  output logic [DW-1:0]       rdata_o,
  output logic [SAW-1:0]      sram_addr_o,
  output logic [DW-1:0]       sram_wdata_o,
  output logic [3:0]          sram_sel_o,
  output logic                sram_wen_o,
  output logic                sram_ren_o,
  input  logic [DW-1:0]       sram_rdata_i,
  input  logic                sram_busy_i
);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   own_q, own_d;
  logic            own_wr_q, own_wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [SAW-1:0]  saddr_q, saddr_d;
  logic [DW-1:0]   swdata_q, swdata_d;
  logic [3:0]      ssel_q, ssel_d;
  logic            swen_q, swen_d;
  logic            sren_q, sren_d;

  logic [NREQ-1:0] sel_grant;
  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [AW-1:0]   addr_w  [NREQ];
  logic [DW-1:0]   wdata_w [NREQ];

  // Unpack per-requester address and write-data slices
  for (genvar k = 0; k < int'(NREQ); k++) begin : g_unpack
    assign addr_w[k]  = addr_i[AW*k +: AW];
    assign wdata_w[k] = wdata_i[DW*k +: DW];
  end

  t05_rr_select u_rr_select (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (sel_grant),
    .valid (sel_valid)
  );

  assign sel_idx = onehot_idx(sel_grant);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    own_wr_d = own_wr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    ssel_d   = ssel_q;
    swen_d   = 1'b0;
    sren_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          // Latch the owner's request bundle; strobe appears in ISSUE
          grant_d  = sel_grant;
          own_d    = sel_idx;
          own_wr_d = wr_i[sel_idx];
          swen_d   = wr_i[sel_idx];
          sren_d   = ~wr_i[sel_idx];
          saddr_d  = region_base(sel_idx) + SAW'({addr_w[sel_idx], 2'b00});
          swdata_d = wdata_w[sel_idx];
          ssel_d   = 4'hF;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // cnt_q == 0 marks the first WAIT cycle, where busy may not yet be up
        if ((cnt_q != '0) && !sram_busy_i) begin
          ack_d   = grant_q;
          state_d = ST_RESP;
          if (!own_wr_q) rdata_d = sram_rdata_i;
        end else if (({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT}) begin
          err_d   = grant_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP: begin
        grant_d  = '0;
        saddr_d  = '0;
        swdata_d = '0;
        ssel_d   = '0;
        ptr_d    = (own_q == IW'(NREQ - 1)) ? '0 : own_q + IW'(1);
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      own_q    <= '0;
      own_wr_q <= 1'b0;
      cnt_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      saddr_q  <= '0;
      swdata_q <= '0;
      ssel_q   <= '0;
      swen_q   <= 1'b0;
      sren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      own_wr_q <= own_wr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      ssel_q   <= ssel_d;
      swen_q   <= swen_d;
      sren_q   <= sren_d;
    end
  end

  assign grant_o      = grant_q;
  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign sram_addr_o  = saddr_q;
  assign sram_wdata_o = swdata_q;
  assign sram_sel_o   = ssel_q;
  assign sram_wen_o   = swen_q;
  assign sram_ren_o   = sren_q;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed bench for t05_sram_arbiter: a table of single transactions
// plus hand-written sequences for reset-in-WAIT and round-robin fairness.
module tb_t05_sram_arbiter;

  logic        clk;
  logic        nrst;
  logic [2:0]  req_i;
  logic [2:0]  wr_i;
  logic [23:0] addr_i;
  logic [95:0] wdata_i;
  logic [2:0]  grant_o;
  logic [2:0]  ack_o;
  logic [2:0]  err_o;
  logic [31:0] rdata_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [3:0]  sram_sel_o;
  logic        sram_wen_o;
  logic        sram_ren_o;
  logic [31:0] sram_rdata_i;
  logic        sram_busy_i;

  int checks = 0;
  int errors = 0;

  t05_sram_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_i        (req_i),
    .wr_i         (wr_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .grant_o      (grant_o),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_sel_o   (sram_sel_o),
    .sram_wen_o   (sram_wen_o),
    .sram_ren_o   (sram_ren_o),
    .sram_rdata_i (sram_rdata_i),
    .sram_busy_i  (sram_busy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [23:0] addr;
    logic [95:0] wdata;
    int          busy_n;     // WAIT cycles with busy high
    logic [31:0] rdata_in;
    bit          drop;       // owner drops req on first WAIT cycle
    logic [2:0]  exp_grant;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          exp_wen;
    int          exp_lat;    // cycles from strobe to ack/err
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
    chk({tag, "_ackerr"}, 32'({ack_o, err_o}), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_saddr"}, sram_addr_o, 32'd0);
    chk({tag, "_swdata"}, sram_wdata_o, 32'd0);
    chk({tag, "_ssel_strobe"}, 32'({sram_sel_o, sram_wen_o, sram_ren_o}), 32'd0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    bit got;
    int k;
    string t;
    t = $sformatf("v%0d", n);
    req_i = v.req; wr_i = v.wr; addr_i = v.addr; wdata_i = v.wdata;
    sram_rdata_i = v.rdata_in; sram_busy_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sram_wen_o || sram_ren_o) begin got = 1'b1; break; end
    end
    chk({t, "_strobe_seen"}, 32'(got), 32'd1);
    chk({t, "_grant"}, 32'(grant_o), 32'(v.exp_grant));
    chk({t, "_saddr"}, sram_addr_o, v.exp_addr);
    chk({t, "_swdata"}, sram_wdata_o, v.exp_wdata);
    chk({t, "_ssel"}, 32'(sram_sel_o), 32'hF);
    chk({t, "_wen_ren"}, 32'({sram_wen_o, sram_ren_o}), 32'({v.exp_wen, ~v.exp_wen}));
    sram_busy_i = (v.busy_n > 0);
    @(negedge clk);
    chk({t, "_strobe_1cyc"}, 32'({sram_wen_o, sram_ren_o}), 32'd0);
    k = 1;
    got = 1'b0;
    while (k < 40) begin
      if (ack_o != 3'b000 || err_o != 3'b000) begin got = 1'b1; break; end
      sram_busy_i = (k <= v.busy_n);
      if (v.drop && k == 1) req_i = 3'b000;
      @(negedge clk);
      k++;
    end
    chk({t, "_resp_seen"}, 32'(got), 32'd1);
    chk({t, "_latency"}, 32'(k), 32'(v.exp_lat));
    chk({t, "_ack"}, 32'(ack_o), v.exp_err ? 32'd0 : 32'(v.exp_grant));
    chk({t, "_err"}, 32'(err_o), v.exp_err ? 32'(v.exp_grant) : 32'd0);
    chk({t, "_resp_grant"}, 32'(grant_o), 32'(v.exp_grant));
    chk({t, "_rdata"}, rdata_o, v.exp_rdata);
    req_i = 3'b000;
    sram_busy_i = 1'b0;
    @(negedge clk);
    chk({t, "_pulse_1cyc"}, 32'({ack_o, err_o}), 32'd0);
    chk({t, "_idle_grant"}, 32'(grant_o), 32'd0);
    chk({t, "_idle_saddr"}, sram_addr_o, 32'd0);
  endtask

  initial begin
    logic [2:0] acks [3];
    int nack;
    int viol;
    bit got;

    vecs[0] = '{3'b001, 3'b000, {8'd0, 8'd0, 8'd65}, 96'd0, 2, 32'd7, 1'b0,
                3'b001, 32'h3300_0104, 32'd0, 1'b0, 4, 1'b0, 32'd7};
    vecs[1] = '{3'b001, 3'b001, {8'd0, 8'd0, 8'd66}, {32'd0, 32'd0, 32'd3}, 1, 32'hFFFF_FFFF, 1'b0,
                3'b001, 32'h3300_0108, 32'd3, 1'b1, 3, 1'b0, 32'd7};
    vecs[2] = '{3'b010, 3'b000, {8'd0, 8'h00, 8'd0}, {32'd0, 32'h0000_1111, 32'd0}, 0, 32'hA5A5_0001, 1'b0,
                3'b010, 32'h3300_0400, 32'h0000_1111, 1'b0, 3, 1'b0, 32'hA5A5_0001};
    vecs[3] = '{3'b100, 3'b100, {8'hFF, 8'd0, 8'd0}, {32'hDEAD_BEEF, 32'd0, 32'd0}, 3, 32'd0, 1'b0,
                3'b100, 32'h3300_0BFC, 32'hDEAD_BEEF, 1'b1, 5, 1'b0, 32'hA5A5_0001};
    vecs[4] = '{3'b010, 3'b000, {8'd0, 8'd2, 8'd0}, 96'd0, 99, 32'h0000_1234, 1'b0,
                3'b010, 32'h3300_0408, 32'd0, 1'b0, 5, 1'b1, 32'hA5A5_0001};
    // ptr must have advanced to 2 after the timed-out owner 1, so 0 wins over 1
    vecs[5] = '{3'b011, 3'b000, {8'd0, 8'd9, 8'd3}, 96'd0, 2, 32'h0000_0055, 1'b1,
                3'b001, 32'h3300_000C, 32'd0, 1'b0, 4, 1'b0, 32'h0000_0055};

    nrst = 1'b0; req_i = '0; wr_i = '0; addr_i = '0; wdata_i = '0;
    sram_rdata_i = '0; sram_busy_i = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset asserted during WAIT, then requester 1 wins from ptr 0
    req_i = 3'b001; wr_i = 3'b000; addr_i = '0; sram_busy_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sram_ren_o) begin got = 1'b1; break; end
    end
    chk("rst_pre_strobe", 32'(got), 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    req_i = 3'b110; sram_busy_i = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_after_grant", 32'(grant_o), 32'b010);
    chk("rst_after_ren", 32'(sram_ren_o), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_o != 3'b000) begin got = 1'b1; break; end
    end
    chk("rst_after_ack", 32'(ack_o), 32'b010);
    req_i = 3'b000;
    @(negedge clk);

    // All three requesters held from reset: served 0,1,2 with no overlap
    nrst = 1'b0; req_i = 3'b111; sram_busy_i = 1'b0;
    for (int i = 0; i < 3; i++) acks[i] = 3'b000;
    nack = 0; viol = 0;
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 60 && nack < 3; c++) begin
      @(negedge clk);
      if ($countones(grant_o) > 1 || $countones(ack_o) > 1 || $countones(err_o) > 1 ||
          (ack_o != 3'b000 && err_o != 3'b000) ||
          (ack_o != 3'b000 && ack_o != grant_o))
        viol++;
      if (ack_o != 3'b000) begin
        acks[nack] = ack_o;
        nack++;
      end
      sram_busy_i = sram_wen_o | sram_ren_o;
    end
    chk("rr_ack_count", 32'(nack), 32'd3);
    chk("rr_ack0", 32'(acks[0]), 32'b001);
    chk("rr_ack1", 32'(acks[1]), 32'b010);
    chk("rr_ack2", 32'(acks[2]), 32'b100);
    chk("rr_overlap", 32'(viol), 32'd0);
    req_i = 3'b000;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
